sumador_serie: RTL and testbench



---
 rtl/sumador_serie.sv | 112 +++++++++++
 tb/tb_sumador_serie.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first, with enb/valid handshake.
// Optional signed-overflow output ovf is enabled by defining SUMADOR_SERIE_OVF_EN.
module sumador_serie #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enb,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             busy,
    output logic             valid
`ifdef SUMADOR_SERIE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-2:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   c_q;
    logic               cout_q;
    logic               valid_q;
`ifdef SUMADOR_SERIE_OVF_EN
    logic               ovf_q;
`endif

    logic               s_d;
    logic               carry_d;
    logic [WIDTH-1:0]   sum_d;
    logic               last_bit;

    always_comb begin
        s_d      = sa_q[0] ^ sb_q[0] ^ carry_q;
        carry_d  = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
        // The bit computed this cycle joins the WIDTH-1 already collected to form the full sum.
        sum_d    = {s_d, sum_q};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enb) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SUM;
                    end
                end
                SUM: begin
                    carry_q <= carry_d;
                    sum_q   <= sum_d[WIDTH-1:1];
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q <= DONE;
                        c_q     <= sum_d;
                        cout_q  <= carry_d;
                        valid_q <= 1'b1;
`ifdef SUMADOR_SERIE_OVF_EN
                        // Carry into the MSB cell differs from carry out of it.
                        ovf_q   <= carry_q ^ carry_d;
`endif
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c     = c_q;
    assign cout  = cout_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);
`ifdef SUMADOR_SERIE_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_serie.sv
// Scoreboard bench for sumador_serie: reference model predicts accepts and results, monitor checks outputs.
// Also checks ovf when SUMADOR_SERIE_OVF_EN is defined.
module tb_sumador_serie;

    localparam int W = 4;

    logic         clk;
    logic         reset_L;
    logic         enb;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         cout;
    logic         busy;
    logic         valid;
`ifdef SUMADOR_SERIE_OVF_EN
    logic         ovf;
`endif

    sumador_serie #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .enb     (enb),
        .a       (a),
        .b       (b),
        .c       (c),
        .cout    (cout),
        .busy    (busy),
        .valid   (valid)
`ifdef SUMADOR_SERIE_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         done_edge;
        logic [W:0] sum;
        logic       ovf;
    } exp_t;

    exp_t       sb_q[$];
    int         edge_cnt   = 0;
    int         next_free  = 0;
    int         busy_until = -1;
    logic [W:0] c_exp      = '0;
    logic       ovf_exp    = 1'b0;
    int         n_cmp      = 0;
    int         n_err      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an idle adder accepts a request; it is free again WIDTH+2 edges later.
    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        if (reset_L && enb && edge_cnt >= next_free) begin
            e.done_edge = edge_cnt + W;
            e.sum       = {1'b0, a} + {1'b0, b};
            e.ovf       = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
            sb_q.push_back(e);
            next_free  = edge_cnt + W + 2;
            busy_until = edge_cnt + W;
        end
    end

    // Monitor: sampled mid-cycle, after the edge that edge_cnt names.
    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = (sb_q.size() > 0) && (sb_q[0].done_edge == edge_cnt);
        chk("valid", 64'(valid), 64'(exp_valid));
        if (exp_valid) begin
            c_exp   = sb_q[0].sum;
            ovf_exp = sb_q[0].ovf;
            void'(sb_q.pop_front());
        end
        chk("sum", 64'({cout, c}), 64'(c_exp));
        chk("busy", 64'(busy), 64'(edge_cnt <= busy_until));
`ifdef SUMADOR_SERIE_OVF_EN
        chk("ovf", 64'(ovf), 64'(ovf_exp));
`endif
    end

    task automatic wait_idle();
        int guard = 0;
        while (edge_cnt + 1 < next_free && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: timeout, got busy expected idle");
        end
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        wait_idle();
        enb = 1'b1;
        a   = av;
        b   = bv;
        @(negedge clk);
        enb = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
    endtask

    task automatic settle();
        repeat (W + 3) @(negedge clk);
    endtask

    initial begin
        reset_L = 1'b0;
        enb     = 1'b0;
        a       = '0;
        b       = '0;
        #1;
        chk("reset_c", 64'(c), 64'(0));
        chk("reset_busy_valid", 64'({busy, valid}), 64'(0));
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);

        issue(4'd0, 4'd1);
        settle();
        issue(4'b0101, 4'b0010);
        settle();
        issue(4'b1111, 4'b0001);
        settle();
        issue(4'b1111, 4'b1111);
        settle();

        // Requests held high while busy must be ignored, not queued.
        wait_idle();
        enb = 1'b1;
        a   = 4'd3;
        b   = 4'd4;
        @(negedge clk);
        a = 4'd9;
        b = 4'd9;
        repeat (2 * W + 6) @(negedge clk);
        enb = 1'b0;
        settle();

        // Asynchronous reset in the middle of an operation.
        issue(4'd6, 4'd6);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_L    = 1'b0;
        sb_q.delete();
        c_exp      = '0;
        ovf_exp    = 1'b0;
        busy_until = -1;
        next_free  = 0;
        #1;
        chk("async_rst_sum", 64'({cout, c}), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_valid", 64'(valid), 64'(0));
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        settle();
        issue(4'd1, 4'd1);
        settle();

        issue(4'b0111, 4'b0001);
        settle();
        issue(4'b1000, 4'b1000);
        settle();
        issue(4'd2, 4'd3);
        settle();

        // Random traffic, including requests and operand churn while busy.
        for (int i = 0; i < 400; i++) begin
            enb = ($urandom_range(0, 2) != 0);
            a   = W'($urandom);
            b   = W'($urandom);
            @(negedge clk);
        end
        enb = 1'b0;
        settle();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
